nios_pio_bidir: RTL

Parametrised Avalon-MM general-purpose I/O slave for the Nios system. Next generation of the fixed-width LED output PIO. Adds per-bit direction control, synchronised input sampling, edge capture with write-1-to-clear, an interrupt mask and a level IRQ, alongside atomic bit set/clear on outputs. Sits on the Nios data master bus and drives board LEDs, switches and GPIO headers.

---
 rtl/nios_pio_pkg.sv | 16 +
 rtl/nios_pio_edge_capture.sv | 57 +++++
 rtl/nios_pio_bidir.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios bidirectional PIO: register word addresses
// and edge-capture mode encodings.
package nios_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_ANY  = 2'd2;

endpackage

// File: rtl/nios_pio_edge_capture.sv
// Input synchroniser, edge detector and sticky edge-capture register.
// A detected edge beats a simultaneous write-1-to-clear on the same bit.
module nios_pio_edge_capture
    import nios_pio_pkg::*;
#(
    parameter int         DATA_WIDTH  = 18,
    parameter logic [1:0] EDGE_TYPE   = EDGE_RISE,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    input  logic [DATA_WIDTH-1:0] clr,
    output logic [DATA_WIDTH-1:0] in_sync,
    output logic [DATA_WIDTH-1:0] edgecap
);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_r;
    logic [DATA_WIDTH-1:0]                  prev_r;
    logic [DATA_WIDTH-1:0]                  edgecap_r;
    logic [DATA_WIDTH-1:0]                  edge_s;

    assign in_sync = sync_r[SYNC_STAGES-1];
    assign edgecap = edgecap_r;

    // Synchroniser chain and one-cycle delayed copy of the synchronised input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detect for the configured capture mode
    always_comb begin
        edge_s = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_s = in_sync & ~prev_r;
            EDGE_FALL: edge_s = ~in_sync & prev_r;
            EDGE_ANY:  edge_s = in_sync ^ prev_r;
            default:   edge_s = in_sync ^ prev_r;
        endcase
    end

    // Sticky capture register with write-1-to-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_r <= '0;
        end else begin
            edgecap_r <= (edgecap_r & ~clr) | edge_s;
        end
    end

endmodule

// File: rtl/nios_pio_bidir.sv
// Avalon-MM GPIO slave: output data with atomic set/clear, per-bit direction,
// synchronised inputs with edge capture, interrupt mask and level IRQ.
module nios_pio_bidir
    import nios_pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 18,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter logic [31:0] DIR_RESET   = 32'h0000_0000,
    parameter logic [1:0]  EDGE_TYPE   = EDGE_RISE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);

    logic                  wr_s;
    logic                  rd_s;
    logic [DATA_WIDTH-1:0] wd_s;
    logic [DATA_WIDTH-1:0] clr_s;
    logic [DATA_WIDTH-1:0] in_sync_s;
    logic [DATA_WIDTH-1:0] edgecap_s;
    logic [31:0]           rd_word_s;

    logic [DATA_WIDTH-1:0] data_out_r;
    logic [DATA_WIDTH-1:0] dir_r;
    logic [DATA_WIDTH-1:0] mask_r;
    logic [31:0]           readdata_r;
    logic                  irq_r;

    assign wr_s     = chipselect & ~write_n;
    assign rd_s     = chipselect & ~read_n;
    assign wd_s     = writedata[DATA_WIDTH-1:0];
    assign out_port = data_out_r;
    assign oe_port  = dir_r;
    assign readdata = readdata_r;
    assign irq      = irq_r;

    // Upper write-data bits beyond the PIO width carry no meaning
    if (DATA_WIDTH < 32) begin : g_unused_wd
        logic unused_wd_s;
        assign unused_wd_s = &{1'b0, writedata[31:DATA_WIDTH]};
    end

    // Write-1-to-clear strobe for the edge-capture register
    always_comb begin
        clr_s = '0;
        if (wr_s && (address == ADDR_EDGECAP)) begin
            clr_s = wd_s;
        end else begin
            clr_s = '0;
        end
    end

    nios_pio_edge_capture #(
        .DATA_WIDTH  (DATA_WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_capture (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .clr     (clr_s),
        .in_sync (in_sync_s),
        .edgecap (edgecap_s)
    );

    // Control register writes, including atomic output set/clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r <= RESET_VALUE[DATA_WIDTH-1:0];
            dir_r      <= DIR_RESET[DATA_WIDTH-1:0];
            mask_r     <= '0;
        end else if (wr_s) begin
            case (address)
                ADDR_DATA:    data_out_r <= wd_s;
                ADDR_DIR:     dir_r      <= wd_s;
                ADDR_IRQMASK: mask_r     <= wd_s;
                ADDR_OUTSET:  data_out_r <= data_out_r | wd_s;
                ADDR_OUTCLR:  data_out_r <= data_out_r & ~wd_s;
                default:      data_out_r <= data_out_r;
            endcase
        end else begin
            data_out_r <= data_out_r;
        end
    end

    // Read mux: DATA shows driven value on outputs, pin value on inputs
    always_comb begin
        rd_word_s = 32'h0000_0000;
        case (address)
            ADDR_DATA:    rd_word_s[DATA_WIDTH-1:0] = (data_out_r & dir_r) | (in_sync_s & ~dir_r);
            ADDR_DIR:     rd_word_s[DATA_WIDTH-1:0] = dir_r;
            ADDR_IRQMASK: rd_word_s[DATA_WIDTH-1:0] = mask_r;
            ADDR_EDGECAP: rd_word_s[DATA_WIDTH-1:0] = edgecap_s;
            default:      rd_word_s = 32'h0000_0000;
        endcase
    end

    // Registered read data (held between reads) and level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'h0000_0000;
            irq_r      <= 1'b0;
        end else begin
            if (rd_s) begin
                readdata_r <= rd_word_s;
            end else begin
                readdata_r <= readdata_r;
            end
            irq_r <= |(edgecap_s & mask_r);
        end
    end

endmodule
